// File: rtl/eig_seq_if.sv
// Handshake bundle between the eigen-pipeline run sequencer and its neighbours
// (param_loader, eig_core, output_loader, host error clear).
interface eig_seq_if;
  logic       ena;
  logic       pl_valid;
  logic       pl_ready;
  logic       core_start;
  logic       core_busy;
  logic       ol_start;
  logic       ol_busy;
  logic       clr_err;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] run_cnt;

  modport slave (
    input  ena, pl_valid, core_busy, ol_busy, clr_err,
    output pl_ready, core_start, ol_start, done, err, err_code, run_cnt
  );

  modport master (
    output ena, pl_valid, core_busy, ol_busy, clr_err,
    input  pl_ready, core_start, ol_start, done, err, err_code, run_cnt
  );
endinterface

// File: rtl/eig_seq_ctrl.sv
// Run sequencer: param_loader -> eig_core -> output_loader, with a guarded timeout
// on every wait and a sticky error state that only clr_err leaves.
module eig_seq_ctrl #(
  parameter int TMR_W   = 16,
  parameter int ACK_TO  = 8,
  parameter int CORE_TO = 4096,
  parameter int OL_TO   = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  eig_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_C_ACK, S_C_RUN, S_O_ACK, S_O_RUN, S_FIN, S_ERR
  } state_t;

  // Compare against LIMIT-1: the check fires in the LIMIT-th cycle spent in the state.
  localparam logic [TMR_W-1:0] ACK_LIM  = TMR_W'(ACK_TO - 1);
  localparam logic [TMR_W-1:0] CORE_LIM = TMR_W'(CORE_TO - 1);
  localparam logic [TMR_W-1:0] OL_LIM   = TMR_W'(OL_TO - 1);

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_pl_ready;
  logic             r_core_start;
  logic             r_ol_start;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [7:0]       r_run_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      r_pl_ready   <= 1'b1;
      r_core_start <= 1'b0;
      r_ol_start   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
      r_run_cnt    <= 8'd0;
    end else if (!bus.ena) begin
      // Frozen: only the single-cycle pulses are dropped.
      r_core_start <= 1'b0;
      r_ol_start   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_ol_start   <= 1'b0;
      r_done       <= 1'b0;
      if (r_tmr != '1) r_tmr <= r_tmr + 1'b1;

      // Success is tested before timeout so a same-cycle success wins.
      case (r_state)
        S_IDLE: begin
          r_tmr <= '0;
          if (bus.pl_valid) begin
            r_state      <= S_C_ACK;
            r_core_start <= 1'b1;
            r_pl_ready   <= 1'b0;
          end
        end
        S_C_ACK: begin
          if (bus.core_busy) begin
            r_state <= S_C_RUN;
            r_tmr   <= '0;
          end else if (r_tmr == ACK_LIM) begin
            r_state    <= S_ERR;
            r_tmr      <= '0;
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
          end
        end
        S_C_RUN: begin
          if (!bus.core_busy) begin
            r_state    <= S_O_ACK;
            r_tmr      <= '0;
            r_ol_start <= 1'b1;
          end else if (r_tmr == CORE_LIM) begin
            r_state    <= S_ERR;
            r_tmr      <= '0;
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
          end
        end
        S_O_ACK: begin
          if (bus.ol_busy) begin
            r_state <= S_O_RUN;
            r_tmr   <= '0;
          end else if (r_tmr == ACK_LIM) begin
            r_state    <= S_ERR;
            r_tmr      <= '0;
            r_err      <= 1'b1;
            r_err_code <= 2'b11;
          end
        end
        S_O_RUN: begin
          if (!bus.ol_busy) begin
            r_state   <= S_FIN;
            r_tmr     <= '0;
            r_done    <= 1'b1;
            r_run_cnt <= r_run_cnt + 8'd1;
          end else if (r_tmr == OL_LIM) begin
            r_state    <= S_ERR;
            r_tmr      <= '0;
            r_err      <= 1'b1;
            r_err_code <= 2'b11;
          end
        end
        S_FIN: begin
          r_state    <= S_IDLE;
          r_tmr      <= '0;
          r_pl_ready <= 1'b1;
        end
        S_ERR: begin
          r_tmr <= '0;
          if (bus.clr_err) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_pl_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tmr      <= '0;
          r_pl_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pl_ready   = r_pl_ready;
  assign bus.core_start = r_core_start;
  assign bus.ol_start   = r_ol_start;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
  assign bus.run_cnt    = r_run_cnt;

endmodule
